// File: rtl/ibex_pkg.sv
// Shared coprocessor-interface (XIF) memory types, exception causes and the
// alignment rule used by the XIF memory bridge.
package ibex_pkg;

  localparam int unsigned X_ID_WIDTH = 4;

  localparam logic [5:0] EXC_CAUSE_LOAD_ADDR_MISALIGNED  = 6'd4;
  localparam logic [5:0] EXC_CAUSE_STORE_ADDR_MISALIGNED = 6'd6;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [31:0]           addr;
    logic [1:0]            mode;
    logic                  we;
    logic [2:0]            size;
    logic [3:0]            be;
    logic [1:0]            attr;
    logic [31:0]           wdata;
    logic                  last;
    logic                  spec;
  } x_mem_req_t;

  typedef struct packed {
    logic       exc;
    logic [5:0] exccode;
    logic       dbg;
  } x_mem_resp_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [31:0]           rdata;
    logic                  err;
    logic                  dbg;
  } x_mem_result_t;

  // Sizes 3 and above are unsupported on a 32-bit bus and treated as misaligned.
  function automatic logic xif_misaligned(input logic [1:0] addr_lo, input logic [2:0] size);
    return (size >= 3'd3) ||
           (size == 3'd1 && addr_lo[0]) ||
           (size == 3'd2 && addr_lo != 2'b00);
  endfunction

endpackage

// File: rtl/xif_mem_align.sv
// Byte-lane steering between the XIF request/result and the 32-bit data bus:
// byte enables, write-data shift and read-data extract with zero extension.
module xif_mem_align (
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  size,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] bus_wdata,
  output logic [31:0] load_data
);

  logic [4:0]  shamt;
  logic [31:0] rdata_shifted;

  always_comb begin
    shamt         = {addr_lo, 3'b000};
    bus_wdata     = wdata << shamt;
    rdata_shifted = rdata >> shamt;

    unique case (size)
      3'd0:    be = 4'b0001 << addr_lo;
      3'd1:    be = 4'b0011 << addr_lo;
      default: be = 4'b1111;
    endcase

    unique case (size)
      3'd0:    load_data = {24'h000000, rdata_shifted[7:0]};
      3'd1:    load_data = {16'h0000, rdata_shifted[15:0]};
      default: load_data = rdata_shifted;
    endcase
  end

endmodule

// File: rtl/xif_mem_bridge.sv
// Bridges XIF coprocessor memory requests onto a single-outstanding data bus,
// with misalignment exceptions, speculative-request hold-off and rvalid timeout.
module xif_mem_bridge
  import ibex_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic          clk_i,
  input  logic          rst_i,

  input  logic          x_mem_valid_i,
  output logic          x_mem_ready_o,
  input  x_mem_req_t    x_mem_req_i,
  output x_mem_resp_t   x_mem_resp_o,

  output logic          x_mem_result_valid_o,
  output x_mem_result_t x_mem_result_o,

  output logic          data_req_o,
  input  logic          data_gnt_i,
  input  logic          data_rvalid_i,
  output logic [31:0]   data_addr_o,
  output logic          data_we_o,
  output logic [3:0]    data_be_o,
  output logic [31:0]   data_wdata_o,
  input  logic [31:0]   data_rdata_i,
  input  logic          data_err_i
);

  typedef enum logic [1:0] {IDLE, BUS_REQ, BUS_WAIT, RESULT} state_e;

  localparam logic [31:0] TimeoutLast = 32'(TimeoutCycles) - 32'd1;

  state_e                state_q;
  logic [X_ID_WIDTH-1:0] id_q;
  logic                  we_q;
  logic [31:0]           addr_q;
  logic [2:0]            size_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rdata_q;
  logic                  err_q;
  logic                  req_q;
  logic                  result_valid_q;
  logic [31:0]           cnt_q;

  logic                  misaligned;
  logic                  ready;
  logic                  accept;
  logic                  timeout;
  logic [31:0]           load_data;
  logic                  unused_req;

  assign unused_req = ^{x_mem_req_i.mode, x_mem_req_i.be, x_mem_req_i.attr, x_mem_req_i.last};

  always_comb begin
    misaligned = xif_misaligned(x_mem_req_i.addr[1:0], x_mem_req_i.size);
    // Misaligned requests are answered immediately even when speculative.
    ready      = !rst_i && (state_q == IDLE) && x_mem_valid_i &&
                 (!x_mem_req_i.spec || misaligned);
    accept     = ready && !misaligned;
    timeout    = (TimeoutCycles != 0) && (cnt_q == TimeoutLast);

    x_mem_resp_o = '0;
    if (ready && misaligned) begin
      x_mem_resp_o.exc     = 1'b1;
      x_mem_resp_o.exccode = x_mem_req_i.we ? EXC_CAUSE_STORE_ADDR_MISALIGNED
                                            : EXC_CAUSE_LOAD_ADDR_MISALIGNED;
    end
  end

  assign x_mem_ready_o = ready;

  xif_mem_align u_align (
    .addr_lo   (addr_q[1:0]),
    .size      (size_q),
    .wdata     (wdata_q),
    .rdata     (data_rdata_i),
    .be        (data_be_o),
    .bus_wdata (data_wdata_o),
    .load_data (load_data)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      id_q           <= '0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      size_q         <= '0;
      wdata_q        <= '0;
      rdata_q        <= '0;
      err_q          <= 1'b0;
      req_q          <= 1'b0;
      result_valid_q <= 1'b0;
      cnt_q          <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            id_q    <= x_mem_req_i.id;
            we_q    <= x_mem_req_i.we;
            addr_q  <= x_mem_req_i.addr;
            size_q  <= x_mem_req_i.size;
            wdata_q <= x_mem_req_i.wdata;
            req_q   <= 1'b1;
            state_q <= BUS_REQ;
          end
        end
        BUS_REQ: begin
          if (data_gnt_i) begin
            req_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= BUS_WAIT;
          end
        end
        BUS_WAIT: begin
          // rvalid wins over a timeout expiring on the same edge.
          if (data_rvalid_i) begin
            err_q          <= data_err_i;
            rdata_q        <= (data_err_i || we_q) ? '0 : load_data;
            result_valid_q <= 1'b1;
            state_q        <= RESULT;
          end else if (timeout) begin
            err_q          <= 1'b1;
            rdata_q        <= '0;
            result_valid_q <= 1'b1;
            state_q        <= RESULT;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        RESULT: begin
          result_valid_q <= 1'b0;
          state_q        <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_req_o           = req_q;
  assign data_addr_o          = {addr_q[31:2], 2'b00};
  assign data_we_o            = we_q;
  assign x_mem_result_valid_o = result_valid_q;

  always_comb begin
    x_mem_result_o       = '0;
    x_mem_result_o.id    = id_q;
    x_mem_result_o.rdata = rdata_q;
    x_mem_result_o.err   = err_q;
    x_mem_result_o.dbg   = 1'b0;
  end

endmodule
